systolic_input_feeder: RTL and testbench

- West-edge feeder for the systolic PE array; it sits directly upstream of column 0 of the PE grid.
- Accepts one vector of ROWS activations per cycle from the activation buffer over a valid/ready handshake.
- Drives each row's input, valid and switch lines with diagonal skew: row r is delayed r cycles relative to row 0.
- Sequences one tile of length len per start command and reports busy/done to the controller.

---
 rtl/systolic_input_feeder.sv | 156 +++++++++++++++
 tb/tb_systolic_input_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_feeder.sv
// West-edge feeder for the systolic PE array: accepts one activation vector per
// cycle and drives each PE row with a diagonal skew of one cycle per row.
module systolic_input_feeder #(
    parameter int unsigned ROWS       = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    input  logic                       switch_en,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic [ROWS*DATA_WIDTH-1:0] out_input,
    output logic [ROWS-1:0]            out_valid,
    output logic [ROWS-1:0]            out_switch
);

    localparam int unsigned CNT_W = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic               first_q, first_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;
    logic               accept;
    logic               tag;

    // in_ready_q is high exactly while the FSM is in STREAM
    assign accept = in_valid & in_ready_q;
    assign tag    = accept & first_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            drain_q    <= '0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        first_d = first_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rem_d   = len;
                        first_d = switch_en;
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    rem_d   = rem_q - LEN_W'(1);
                    first_d = 1'b0;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                        drain_d = CNT_W'(ROWS);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status outputs are registered copies of the next state
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        in_ready_d = (state_d == S_STREAM);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;

    // Row r: r+1 skew registers plus the output register; bubbles carry zero data
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int unsigned DEPTH = r + 2;

        logic [DEPTH-1:0]      v_q, v_d;
        logic [DEPTH-1:0]      s_q, s_d;
        logic [DATA_WIDTH-1:0] d_q [DEPTH];
        logic [DATA_WIDTH-1:0] d_d [DEPTH];

        always_comb begin
            v_d    = {v_q[DEPTH-2:0], accept};
            s_d    = {s_q[DEPTH-2:0], tag};
            d_d[0] = accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int j = 1; j < DEPTH; j++) begin
                d_d[j] = d_q[j-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                s_q <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    d_q[j] <= '0;
                end
            end else begin
                v_q <= v_d;
                s_q <= s_d;
                for (int j = 0; j < DEPTH; j++) begin
                    d_q[j] <= d_d[j];
                end
            end
        end

        assign out_valid[r]                              = v_q[DEPTH-1];
        assign out_switch[r]                             = s_q[DEPTH-1];
        assign out_input[r*DATA_WIDTH +: DATA_WIDTH]     = d_q[DEPTH-1];
    end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Bench for systolic_input_feeder: directed tiles plus random tiles, every cycle
// compared against a per-edge accept log that derives the skewed outputs.
module tb_systolic_input_feeder;

    localparam int ROWS = 2;
    localparam int DW   = 16;
    localparam int LW   = 8;
    localparam int MAXC = 4096;
    localparam int BIG  = 1 << 30;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LW-1:0]        len;
    logic                 switch_en;
    logic                 busy;
    logic                 done;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic [ROWS*DW-1:0]   out_input;
    logic [ROWS-1:0]      out_valid;
    logic [ROWS-1:0]      out_switch;

    systolic_input_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .switch_en(switch_en),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_input(out_input), .out_valid(out_valid),
        .out_switch(out_switch)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: log of what was accepted at each edge, plus tile bookkeeping
    int               cyc = 0;
    int               floor_e = 0;
    int               done_edge = BIG;
    int               m_rem = 0;
    bit               m_active = 1'b0;
    bit               m_first = 1'b0;
    bit               acc_v [MAXC];
    bit               acc_s [MAXC];
    logic [ROWS*DW-1:0] acc_d [MAXC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs(input int e);
        logic [ROWS-1:0]    ev;
        logic [ROWS-1:0]    es;
        logic [ROWS*DW-1:0] ed;
        int                 idx;
        ev = '0; es = '0; ed = '0;
        for (int r = 0; r < ROWS; r++) begin
            idx = e - 1 - r;
            if (idx >= floor_e && idx >= 0 && acc_v[idx]) begin
                ev[r]           = 1'b1;
                es[r]           = acc_s[idx];
                ed[r*DW +: DW]  = acc_d[idx][r*DW +: DW];
            end
        end
        chk("out_valid",  64'(out_valid),  64'(ev));
        chk("out_switch", 64'(out_switch), 64'(es));
        chk("out_input",  64'(out_input),  64'(ed));
        chk("in_ready",   64'(in_ready),   64'(m_rem > 0));
        chk("busy",       64'(busy),       64'(m_active && e <= done_edge));
        chk("done",       64'(done),       64'(m_active && e == done_edge));
    endtask

    task automatic tick();
        int e;
        bit acc;
        e   = cyc + 1;
        acc = in_valid && (m_rem > 0);
        acc_v[e] = acc;
        acc_s[e] = acc && m_first;
        acc_d[e] = in_data;
        if (acc) begin
            m_first = 1'b0;
            m_rem--;
            if (m_rem == 0) done_edge = e + ROWS + 1;
        end
        if (start && !m_active) begin
            m_active = 1'b1;
            if (len == '0) begin
                done_edge = e;
            end else begin
                m_rem     = int'(len);
                m_first   = switch_en;
                done_edge = BIG;
            end
        end
        @(posedge clk);
        cyc = e;
        #1;
        check_outputs(e);
        if (m_active && e > done_edge) m_active = 1'b0;
    endtask

    task automatic drv(input bit st, input int ln, input bit sw, input bit v,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        start     = st;
        len       = LW'(ln);
        switch_en = sw;
        in_valid  = v;
        in_data   = {d1, d0};
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 200;
        while (m_active && budget > 0) begin
            drv(0, 0, 0, 0, '0, '0);
            budget--;
        end
        chk("idle_timeout", 64'(m_active), 64'(0));
        drv(0, 0, 0, 0, '0, '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"},  64'(out_valid),  64'(0));
        chk({tag, "_out_switch"}, 64'(out_switch), 64'(0));
        chk({tag, "_out_input"},  64'(out_input),  64'(0));
        chk({tag, "_in_ready"},   64'(in_ready),   64'(0));
        chk({tag, "_busy"},       64'(busy),       64'(0));
        chk({tag, "_done"},       64'(done),       64'(0));
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        m_active  = 1'b0;
        m_rem     = 0;
        m_first   = 1'b0;
        done_edge = BIG;
        check_zero_outputs("rst_async");
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        floor_e = cyc + 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst = 1'b1; start = 1'b0; len = '0; switch_en = 1'b0;
        in_valid = 1'b0; in_data = '0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        floor_e = 1;

        // Tile of three vectors with switch, in_valid held
        drv(1, 3, 1, 0, '0, '0);
        drv(0, 0, 0, 1, 16'd1, 16'd10);
        drv(0, 0, 0, 1, 16'd2, 16'd20);
        drv(0, 0, 0, 1, 16'd3, 16'd30);
        chk("s1_skew_snapshot", 64'(out_input), 64'({16'd10, 16'd2}));
        wait_idle();

        // Bubble between two vectors, negative data
        drv(1, 2, 0, 0, '0, '0);
        drv(0, 0, 0, 1, 16'd5, -16'sd5);
        drv(0, 0, 0, 0, 16'hAAAA, 16'h5555);
        drv(0, 0, 0, 1, 16'd7, -16'sd7);
        chk("bubble_row1_neg", 64'(out_input[2*DW-1:DW]), 64'(16'hFFFB));
        chk("bubble_valid",    64'(out_valid), 64'(2'b10));
        wait_idle();

        // Zero-length tile
        drv(1, 0, 1, 1, 16'd9, 16'd9);
        chk("len0_done", 64'(done), 64'(1));
        wait_idle();

        // start during STREAM is ignored
        drv(1, 3, 1, 0, '0, '0);
        drv(1, 5, 0, 1, 16'd11, 16'd12);
        drv(1, 1, 0, 1, 16'd13, 16'd14);
        drv(0, 0, 0, 1, 16'd15, 16'd16);
        drv(1, 7, 1, 1, 16'd17, 16'd18);
        wait_idle();

        // switch_en = 0
        drv(1, 3, 0, 0, '0, '0);
        drv(0, 0, 0, 1, 16'd1, 16'd10);
        drv(0, 0, 0, 1, 16'd2, 16'd20);
        drv(0, 0, 0, 1, 16'd3, 16'd30);
        wait_idle();

        // Async reset during DRAIN, then a clean tile
        drv(1, 2, 1, 0, '0, '0);
        drv(0, 0, 0, 1, 16'h1234, 16'h4321);
        drv(0, 0, 0, 1, 16'h8000, 16'h7FFF);
        async_reset();
        repeat (6) drv(0, 0, 0, 0, '0, '0);
        drv(1, 2, 1, 0, '0, '0);
        drv(0, 0, 0, 1, 16'hBEEF, 16'hCAFE);
        drv(0, 0, 0, 1, 16'h0F0F, 16'hF0F0);
        wait_idle();

        // Random tiles with random bubbles, data and spurious starts
        for (int t = 0; t < 8; t++) begin
            drv(1, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            budget = 200;
            while (m_active && budget > 0) begin
                drv(($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                    16'($urandom), 16'($urandom));
                budget--;
            end
            chk("rand_timeout", 64'(m_active), 64'(0));
            drv(0, 0, 0, 1, 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
